// File: rtl/alu_operand_collector.sv
// Collects A/B operand beats for one ALU command and issues them together as a single registered transaction.
// Optional macro ALU_COLLECT_TIMEOUT_EN: issue a partial operand set after TIMEOUT cycles in WAIT.
module alu_operand_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CE,
    input  logic [1:0]            in_valid,
    input  logic [DATA_WIDTH-1:0] in_opa,
    input  logic [DATA_WIDTH-1:0] in_opb,
    input  logic [CMD_WIDTH-1:0]  in_cmd,
    input  logic                  in_mode,
    input  logic                  in_cin,
    output logic [DATA_WIDTH-1:0] OPA,
    output logic [DATA_WIDTH-1:0] OPB,
    output logic [CMD_WIDTH-1:0]  CMD,
    output logic                  MODE,
    output logic                  CIN,
    output logic [1:0]            INP_VALID,
    output logic                  issue,
    output logic                  timeout_err,
    output logic                  busy
);
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            have_q, have_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic                  mode_q, mode_d, cin_q, cin_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [CMD_WIDTH-1:0]  ocmd_q, ocmd_d;
    logic                  omode_q, omode_d, ocin_q, ocin_d;
    logic [1:0]            inpv_q, inpv_d;
    logic                  issue_q, issue_d, busy_q, busy_d;
    logic [1:0]            need_new, need_held;
`ifdef ALU_COLLECT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tmo_q, tmo_d;
`endif

    // Returns {B needed, A needed} for a command.
    function automatic logic [1:0] need_f(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
        logic [31:0] c;
        logic [1:0]  r;
        c = 32'(cmd);
        r = 2'b00;
        if (mode) begin
            if (c <= 32'd3 || (c >= 32'd8 && c <= 32'd10)) r = 2'b11;
            else if (c == 32'd4 || c == 32'd5)             r = 2'b01;
            else if (c == 32'd6 || c == 32'd7)             r = 2'b10;
        end else begin
            if (c <= 32'd5 || c == 32'd12 || c == 32'd13)        r = 2'b11;
            else if (c == 32'd6 || c == 32'd8 || c == 32'd9)     r = 2'b01;
            else if (c == 32'd7 || c == 32'd10 || c == 32'd11)   r = 2'b10;
        end
        return r;
    endfunction

    assign need_new  = need_f(in_mode, in_cmd);
    assign need_held = need_f(mode_q, cmd_q);

    always_comb begin
        state_d = state_q;
        have_d  = have_q;
        a_d     = a_q;
        b_d     = b_q;
        cmd_d   = cmd_q;
        mode_d  = mode_q;
        cin_d   = cin_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        ocmd_d  = ocmd_q;
        omode_d = omode_q;
        ocin_d  = ocin_q;
        inpv_d  = 2'b00;
        issue_d = 1'b0;
        busy_d  = busy_q;
`ifdef ALU_COLLECT_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        if (CE) begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid != 2'b00) begin
                        cmd_d  = in_cmd;
                        mode_d = in_mode;
                        cin_d  = in_cin;
                        have_d = in_valid;
                        // An operand not offered at acceptance starts from zero, not a stale value.
                        a_d    = in_valid[0] ? in_opa : '0;
                        b_d    = in_valid[1] ? in_opb : '0;
                        if ((in_valid & need_new) == need_new) begin
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_WAIT;
`ifdef ALU_COLLECT_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    if (in_valid[0] && !have_q[0]) a_d = in_opa;
                    if (in_valid[1] && !have_q[1]) b_d = in_opb;
                    have_d = have_q | in_valid;
                    if ((have_d & need_held) == need_held) begin
                        state_d = S_ISSUE;
                    end
`ifdef ALU_COLLECT_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = S_ISSUE;
                        tmo_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                S_ISSUE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            busy_d = (state_d != S_IDLE);
            if (state_d == S_ISSUE) begin
                issue_d = 1'b1;
                inpv_d  = have_d;
                opa_d   = a_d;
                opb_d   = b_d;
                ocmd_d  = cmd_d;
                omode_d = mode_d;
                ocin_d  = cin_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            have_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            ocmd_q  <= '0;
            omode_q <= 1'b0;
            ocin_q  <= 1'b0;
            inpv_q  <= 2'b00;
            issue_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ALU_COLLECT_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            have_q  <= have_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ocmd_q  <= ocmd_d;
            omode_q <= omode_d;
            ocin_q  <= ocin_d;
            inpv_q  <= inpv_d;
            issue_q <= issue_d;
            busy_q  <= busy_d;
`ifdef ALU_COLLECT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign OPA       = opa_q;
    assign OPB       = opb_q;
    assign CMD       = ocmd_q;
    assign MODE      = omode_q;
    assign CIN       = ocin_q;
    assign INP_VALID = inpv_q;
    assign issue     = issue_q;
    assign busy      = busy_q;
`ifdef ALU_COLLECT_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_operand_collector.sv
// Scoreboard bench for alu_operand_collector: a reference model predicts each issue, a monitor checks every cycle.
`timescale 1ns/1ps
module tb_alu_operand_collector;
    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int TMO = 16;
`ifdef ALU_COLLECT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic [1:0]    in_valid = 2'b00;
    logic [DW-1:0] in_opa = '0, in_opb = '0;
    logic [CW-1:0] in_cmd = '0;
    logic          in_mode = 1'b0, in_cin = 1'b0;
    logic [DW-1:0] OPA, OPB;
    logic [CW-1:0] CMD;
    logic          MODE, CIN, issue, timeout_err, busy;
    logic [1:0]    INP_VALID;

    alu_operand_collector #(.DATA_WIDTH(DW), .CMD_WIDTH(CW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .CE(ce), .in_valid(in_valid), .in_opa(in_opa), .in_opb(in_opb),
        .in_cmd(in_cmd), .in_mode(in_mode), .in_cin(in_cin), .OPA(OPA), .OPB(OPB), .CMD(CMD),
        .MODE(MODE), .CIN(CIN), .INP_VALID(INP_VALID), .issue(issue), .timeout_err(timeout_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            stamp;
        logic [DW-1:0] a, b;
        logic [CW-1:0] cmd;
        logic          mode, cin, tmo;
        logic [1:0]    v;
    } exp_t;

    exp_t sbq[$];
    exp_t hold;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   exp_busy = 1'b0;

    // Reference model state: one outstanding command at most.
    bit            m_pending = 1'b0, m_issuing = 1'b0;
    int            m_wait = 0;
    logic [1:0]    m_have = 2'b00;
    logic [DW-1:0] m_a = '0, m_b = '0;
    logic [CW-1:0] m_cmd = '0;
    logic          m_mode = 1'b0, m_cin = 1'b0;

    function automatic logic [1:0] req_ops(input logic mode, input int cmd);
        if (mode) begin
            if (cmd inside {[0:3], [8:10]}) return 2'b11;
            if (cmd inside {4, 5})          return 2'b01;
            if (cmd inside {6, 7})          return 2'b10;
        end else begin
            if (cmd inside {[0:5], 12, 13}) return 2'b11;
            if (cmd inside {6, 8, 9})       return 2'b01;
            if (cmd inside {7, 10, 11})     return 2'b10;
        end
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_issue(input logic tmo);
        exp_t e;
        e.stamp = cyc + 1;
        e.a = m_a; e.b = m_b; e.cmd = m_cmd; e.mode = m_mode; e.cin = m_cin;
        e.v = m_have; e.tmo = tmo;
        sbq.push_back(e);
        hold = e;
        m_issuing = 1'b1;
        m_pending = 1'b0;
    endtask

    initial begin
        hold = '{default: '0};
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pending = 1'b0;
                m_issuing = 1'b0;
                hold      = '{default: '0};
                exp_busy  = 1'b0;
            end else if (ce) begin
                if (m_issuing) begin
                    m_issuing = 1'b0;
                end else if (!m_pending) begin
                    if (in_valid != 2'b00) begin
                        m_cmd = in_cmd; m_mode = in_mode; m_cin = in_cin; m_have = in_valid;
                        m_a = in_valid[0] ? in_opa : '0;
                        m_b = in_valid[1] ? in_opb : '0;
                        if ((m_have & req_ops(m_mode, int'(m_cmd))) == req_ops(m_mode, int'(m_cmd)))
                            m_issue(1'b0);
                        else begin
                            m_pending = 1'b1;
                            m_wait = 0;
                        end
                    end
                end else begin
                    if (in_valid[0] && !m_have[0]) m_a = in_opa;
                    if (in_valid[1] && !m_have[1]) m_b = in_opb;
                    m_have = m_have | in_valid;
                    if ((m_have & req_ops(m_mode, int'(m_cmd))) == req_ops(m_mode, int'(m_cmd)))
                        m_issue(1'b0);
                    else if (TMO_EN && m_wait == TMO - 1)
                        m_issue(1'b1);
                    else
                        m_wait++;
                end
                exp_busy = m_pending || m_issuing;
            end
        end
    end

    // Monitor: samples 1 ns after each rising edge.
    initial begin
        exp_t e;
        bit   due;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            due = (sbq.size() > 0) && (sbq[0].stamp == cyc);
            chk("issue", 32'(issue), 32'(due));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (due) begin
                e = sbq.pop_front();
                $display("ISSUE cyc=%0d mode=%0b cmd=%0d cin=%0b opa=%02h opb=%02h inp_valid=%02b tmo=%0b",
                         cyc, MODE, CMD, CIN, OPA, OPB, INP_VALID, timeout_err);
                chk("opa", 32'(OPA), 32'(e.a));
                chk("opb", 32'(OPB), 32'(e.b));
                chk("cmd", 32'(CMD), 32'(e.cmd));
                chk("mode", 32'(MODE), 32'(e.mode));
                chk("cin", 32'(CIN), 32'(e.cin));
                chk("inp_valid", 32'(INP_VALID), 32'(e.v));
                chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
            end else begin
                chk("idle_inp_valid", 32'(INP_VALID), 32'd0);
                chk("idle_timeout_err", 32'(timeout_err), 32'd0);
                chk("hold_opa", 32'(OPA), 32'(hold.a));
                chk("hold_opb", 32'(OPB), 32'(hold.b));
                chk("hold_cmd", 32'(CMD), 32'(hold.cmd));
                chk("hold_mode", 32'(MODE), 32'(hold.mode));
                chk("hold_cin", 32'(CIN), 32'(hold.cin));
            end
        end
    end

    task automatic beat(input logic c, input logic [1:0] v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [CW-1:0] cmd, input logic md, input int n);
        for (int i = 0; i < n; i++) begin
            ce = c; in_valid = v; in_opa = a; in_opb = b; in_cmd = cmd; in_mode = md;
            in_cin = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic idle(input logic c, input int n);
        for (int i = 0; i < n; i++)
            beat(c, 2'b00, DW'($urandom), DW'($urandom), CW'($urandom), 1'($urandom), 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle(1'($urandom), 1);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle(1'b1, 3);
        rst = 1'b0;
        idle(1'b1, 2);
        beat(1'b1, 2'b11, 8'h12, 8'h34, 4'd0, 1'b1, 1);          // complete single beat
        idle(1'b1, 3);
        beat(1'b1, 2'b01, 8'hA5, 8'h00, 4'd0, 1'b1, 1);          // split operands
        idle(1'b1, 2);
        beat(1'b1, 2'b10, 8'h00, 8'h5A, 4'd0, 1'b1, 1);
        idle(1'b1, 3);
        beat(1'b1, 2'b01, 8'hFF, 8'h00, 4'd4, 1'b1, 1);          // single-operand command
        idle(1'b1, 3);
        beat(1'b1, 2'b01, 8'h3C, 8'h00, 4'd1, 1'b0, 1);          // timeout / endless wait
        idle(1'b1, 45);
        pulse_reset();
        idle(1'b1, 2);
        beat(1'b1, 2'b01, 8'h66, 8'h00, 4'd1, 1'b0, 1);          // CE freeze inside WAIT
        idle(1'b1, 4);
        idle(1'b0, 5);
        idle(1'b1, 40);
        pulse_reset();
        idle(1'b1, 2);
        beat(1'b1, 2'b01, 8'h81, 8'h00, 4'd1, 1'b0, 1);          // reset while waiting
        idle(1'b1, 1);
        pulse_reset();
        idle(1'b1, 2);
        beat(1'b1, 2'b10, 8'h00, 8'h77, 4'd6, 1'b1, 1);
        idle(1'b1, 3);
        beat(1'b1, 2'b11, 8'hC3, 8'h3C, 4'd15, 1'b0, 1);         // no-operand command, CE low in ISSUE
        idle(1'b0, 2);
        idle(1'b1, 3);
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            beat(1'($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 DW'($urandom), DW'($urandom), CW'($urandom), 1'($urandom), 1);
        end
        rst = 1'b0;
        idle(1'b1, 3);
        pulse_reset();
        idle(1'b1, 3);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
